// File: rtl/graph_mem_arbiter.sv
// Purpose: round-robin share of one in-order graph memory read port among NUM_REQ requesters, with tagged response steering.
// Latency: request reaches mem_req_out 1 cycle after accept; response reaches resp_valid_out 1 cycle after mem_resp_valid_in.
// Backpressure: the issue register holds under mem_req_ready_in low; grants stop while it is full or MAX_OUTSTANDING reads are in flight.
module graph_mem_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int PROC_BITS       = 4,
  parameter int DATA_SIZE       = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [NUM_REQ-1:0]                  req_valid_in,
  input  logic [DATA_SIZE-1:0]                req_addr_in [NUM_REQ],
  output logic [NUM_REQ-1:0]                  req_ready_out,
  output logic [NUM_REQ-1:0]                  resp_valid_out,
  output logic [DATA_SIZE-1:0]                resp_data_out,
  output logic                                mem_req_valid_out,
  output logic [PROC_BITS+DATA_SIZE-1:0]      mem_req_out,
  input  logic                                mem_req_ready_in,
  input  logic                                mem_resp_valid_in,
  input  logic [DATA_SIZE-1:0]                mem_resp_data_in,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_out,
  output logic                                err_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PROC_BITS-1:0] tag;
    logic [DATA_SIZE-1:0] addr;
  } mem_req_t;

  logic                 iss_vld_q, iss_vld_d;
  mem_req_t             iss_dat_q, iss_dat_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [PROC_BITS-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [PROC_BITS-1:0] tag_mem_d [MAX_OUTSTANDING];
  logic [NUM_REQ-1:0]   resp_vld_q, resp_vld_d;
  logic [DATA_SIZE-1:0] resp_dat_q, resp_dat_d;
  logic                 err_q, err_d;

  logic                 mem_fire;
  logic                 can_load;
  logic                 fifo_empty;
  logic                 rsp_pop;
  logic [PROC_BITS-1:0] head_tag;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        cand;
  logic                 accept;

  assign mem_fire   = iss_vld_q & mem_req_ready_in;
  assign can_load   = ~iss_vld_q | mem_fire;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // A tag pushed this cycle is not yet visible, so a same-cycle response sees an empty FIFO.
  assign rsp_pop    = mem_resp_valid_in & ~fifo_empty;
  assign head_tag   = tag_mem_q[rd_ptr_q[AW-1:0]];

  // Round-robin search: scan from the far end back toward the pointer so the nearest valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid_in[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept        = gnt_vld & can_load & (cnt_q < CW'(MAX_OUTSTANDING));
  assign req_ready_out = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

  // Next-state for issue register, pointer, count, tag FIFO, response and error flag.
  always_comb begin
    iss_vld_d = iss_vld_q;
    iss_dat_d = iss_dat_q;
    if (mem_fire) iss_vld_d = 1'b0;
    if (accept) begin
      iss_vld_d      = 1'b1;
      iss_dat_d.tag  = PROC_BITS'(gnt_idx);
      iss_dat_d.addr = req_addr_in[gnt_idx];
    end

    ptr_d = accept ? PW'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;
    cnt_d = cnt_q + CW'(accept) - CW'(rsp_pop);

    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    if (mem_fire) begin
      tag_mem_d[wr_ptr_q[AW-1:0]] = iss_dat_q.tag;
      wr_ptr_d                    = wr_ptr_q + (AW+1)'(1);
    end
    rd_ptr_d = rd_ptr_q + (AW+1)'(rsp_pop);

    resp_vld_d = rsp_pop ? (NUM_REQ'(1) << head_tag) : '0;
    resp_dat_d = rsp_pop ? mem_resp_data_in : resp_dat_q;
    err_d      = err_q | (mem_resp_valid_in & fifo_empty);
  end

  // State registers; reset discards every in-flight read.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      iss_vld_q  <= 1'b0;
      iss_dat_q  <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_mem_q  <= '{default: '0};
      resp_vld_q <= '0;
      resp_dat_q <= '0;
      err_q      <= 1'b0;
    end else begin
      iss_vld_q  <= iss_vld_d;
      iss_dat_q  <= iss_dat_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_mem_q  <= tag_mem_d;
      resp_vld_q <= resp_vld_d;
      resp_dat_q <= resp_dat_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_valid_out = iss_vld_q;
  assign mem_req_out       = iss_dat_q;
  assign resp_valid_out    = resp_vld_q;
  assign resp_data_out     = resp_dat_q;
  assign outstanding_out   = cnt_q;
  assign err_out           = err_q;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Purpose: randomized plus directed bench for graph_mem_arbiter against a queue-based reference model.
// Latency: one model step per clock; outputs sampled 1 time unit after the falling edge.
// Backpressure: memory ready and responses are driven by the bench's own in-order memory.
module tb_graph_mem_arbiter;
  localparam int N    = 4;
  localparam int PB   = 4;
  localparam int DW   = 32;
  localparam int MAXO = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [N-1:0]  req_valid_in;
  logic [DW-1:0] req_addr_in [N];
  logic [N-1:0]  req_ready_out;
  logic [N-1:0]  resp_valid_out;
  logic [DW-1:0] resp_data_out;
  logic          mem_req_valid_out;
  logic [PB+DW-1:0] mem_req_out;
  logic          mem_req_ready_in;
  logic          mem_resp_valid_in;
  logic [DW-1:0] mem_resp_data_in;
  logic [3:0]    outstanding_out;
  logic          err_out;

  always #5 clk_in = ~clk_in;

  graph_mem_arbiter #(.NUM_REQ(N), .PROC_BITS(PB), .DATA_SIZE(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_ready_out(req_ready_out),
    .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
    .mem_req_valid_out(mem_req_valid_out), .mem_req_out(mem_req_out), .mem_req_ready_in(mem_req_ready_in),
    .mem_resp_valid_in(mem_resp_valid_in), .mem_resp_data_in(mem_resp_data_in),
    .outstanding_out(outstanding_out), .err_out(err_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a held request (at most one), a queue of issued tags, and the round-robin start point.
  int            rr;
  bit            pend_has;
  int            pend_tag;
  logic [DW-1:0] pend_addr;
  int            inflight[$];
  bit            m_err;
  logic [N-1:0]  m_resp_vld;
  logic [DW-1:0] m_resp_dat;
  logic [DW-1:0] next_addr [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rr = 0;
    pend_has = 0;
    pend_tag = 0;
    pend_addr = '0;
    inflight.delete();
    m_err = 0;
    m_resp_vld = '0;
    m_resp_dat = '0;
  endtask

  // One clock: drive inputs, compare every output with the model, then advance the model across the edge.
  task automatic step(input logic [N-1:0] rv, input logic mrdy, input logic rspv,
                      input logic [DW-1:0] rspd, input logic rst);
    int  g;
    int  cnt;
    int  h;
    int  idx;
    bit  fire;
    bit  canl;
    @(negedge clk_in);
    rst_in            = rst;
    req_valid_in      = rv;
    mem_req_ready_in  = mrdy;
    mem_resp_valid_in = rspv;
    mem_resp_data_in  = rspd;
    for (int i = 0; i < N; i++) req_addr_in[i] = next_addr[i];
    #1;
    check("mem_req_valid", 64'(mem_req_valid_out), 64'(pend_has));
    if (pend_has) check("mem_req", 64'(mem_req_out), 64'({PB'(pend_tag), pend_addr}));
    check("outstanding", 64'(outstanding_out), 64'(int'(pend_has) + inflight.size()));
    check("resp_valid", 64'(resp_valid_out), 64'(m_resp_vld));
    check("resp_data", 64'(resp_data_out), 64'(m_resp_dat));
    check("err", 64'(err_out), 64'(m_err));

    cnt  = int'(pend_has) + inflight.size();
    fire = pend_has && mrdy;
    canl = !pend_has || fire;
    g = -1;
    if (canl && cnt < MAXO) begin
      for (int i = 0; i < N; i++) begin
        idx = (rr + i) % N;
        if (g < 0 && rv[idx]) g = idx;
      end
    end
    if (rst) begin
      model_reset();
    end else begin
      check("req_ready", 64'(req_ready_out), (g >= 0) ? 64'(1) << g : 64'(0));
      m_resp_vld = '0;
      if (rspv) begin
        if (inflight.size() > 0) begin
          h = inflight.pop_front();
          m_resp_vld = N'(1) << h;
          m_resp_dat = rspd;
        end else begin
          m_err = 1;
        end
      end
      if (fire) begin
        inflight.push_back(pend_tag);
        pend_has = 0;
      end
      if (g >= 0) begin
        pend_has  = 1;
        pend_tag  = g;
        pend_addr = req_addr_in[g];
        rr        = (g + 1) % N;
      end
    end
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  logic [N-1:0]  rr_exp [5];
  logic [DW-1:0] rsp_words [4];
  logic [N-1:0]  rsp_owner [4];
  int            n_acc;
  logic [N-1:0]  rv_r;
  logic          rspv_r;

  initial begin
    rst_in = 1'b1;
    req_valid_in = '0;
    mem_req_ready_in = 1'b0;
    mem_resp_valid_in = 1'b0;
    mem_resp_data_in = '0;
    for (int i = 0; i < N; i++) begin
      next_addr[i] = '0;
      req_addr_in[i] = '0;
    end
    repeat (2) @(posedge clk_in);
    model_reset();

    // Reset state, pinned with literals.
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rst_mem_req_valid", 64'(mem_req_valid_out), 64'd0);
    check("rst_mem_req", 64'(mem_req_out), 64'd0);
    check("rst_outstanding", 64'(outstanding_out), 64'd0);
    check("rst_resp_valid", 64'(resp_valid_out), 64'd0);
    check("rst_resp_data", 64'(resp_data_out), 64'd0);
    check("rst_err", 64'(err_out), 64'd0);

    // Single read through requester 1.
    next_addr[1] = 32'h40;
    step(4'b0010, 1'b1, 1'b0, '0, 1'b0);
    check("t1_grant", 64'(req_ready_out), 64'b0010);
    step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
    check("t1_mem_req", 64'(mem_req_out), 64'h1_0000_0040);
    check("t1_outstanding", 64'(outstanding_out), 64'd1);
    step(4'b0000, 1'b1, 1'b1, 32'hDEAD, 1'b0);
    step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
    check("t1_resp_valid", 64'(resp_valid_out), 64'b0010);
    check("t1_resp_data", 64'(resp_data_out), 64'hDEAD);
    check("t1_outstanding_end", 64'(outstanding_out), 64'd0);

    // Round-robin with all requesters valid.
    do_reset();
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 1'b0, '0, 1'b0);
      check("t2_rr_grant", 64'(req_ready_out), 64'(rr_exp[k]));
    end

    // Memory backpressure holds the issue register.
    do_reset();
    next_addr[2] = 32'h10;
    next_addr[3] = 32'h20;
    step(4'b0100, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'b1000, 1'b0, 1'b0, '0, 1'b0);
      check("t3_hold", 64'(mem_req_out), 64'h2_0000_0010);
      check("t3_no_grant", 64'(req_ready_out), 64'd0);
    end
    step(4'b1000, 1'b1, 1'b0, '0, 1'b0);
    check("t3_drain_grant", 64'(req_ready_out), 64'b1000);
    step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
    check("t3_next_req", 64'(mem_req_out), 64'h3_0000_0020);

    // Outstanding limit with a silent memory.
    do_reset();
    n_acc = 0;
    for (int k = 0; k < 10; k++) begin
      step(4'b1111, 1'b1, 1'b0, '0, 1'b0);
      if (req_ready_out != '0) n_acc++;
    end
    check("t4_accepted", 64'(n_acc), 64'd8);
    step(4'b1111, 1'b1, 1'b0, '0, 1'b0);
    check("t4_full_count", 64'(outstanding_out), 64'd8);
    check("t4_full_ready", 64'(req_ready_out), 64'd0);
    step(4'b1111, 1'b1, 1'b1, 32'h1234, 1'b0);
    check("t4_resp_cycle_ready", 64'(req_ready_out), 64'd0);
    step(4'b1111, 1'b1, 1'b0, '0, 1'b0);
    check("t4_one_more", 64'(req_ready_out != '0), 64'd1);
    step(4'b1111, 1'b1, 1'b0, '0, 1'b0);
    check("t4_refull_count", 64'(outstanding_out), 64'd8);
    check("t4_refull_ready", 64'(req_ready_out), 64'd0);

    // In-order response steering.
    do_reset();
    step(4'b1000, 1'b1, 1'b0, '0, 1'b0);
    step(4'b0001, 1'b1, 1'b0, '0, 1'b0);
    step(4'b1000, 1'b1, 1'b0, '0, 1'b0);
    step(4'b0100, 1'b1, 1'b0, '0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
    rsp_words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    rsp_owner = '{4'b1000, 4'b0001, 4'b1000, 4'b0100};
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, 1'b1, k < 4, (k < 4) ? rsp_words[k % 4] : 32'h0, 1'b0);
      if (k > 0) begin
        check("t5_owner", 64'(resp_valid_out), 64'(rsp_owner[k-1]));
        check("t5_data", 64'(resp_data_out), 64'(rsp_words[k-1]));
      end
    end

    // Spurious response, then reset with reads in flight.
    do_reset();
    step(4'b0000, 1'b0, 1'b1, 32'h5555, 1'b0);
    step(4'b0000, 1'b0, 1'b0, '0, 1'b0);
    check("t6_err", 64'(err_out), 64'd1);
    check("t6_no_resp", 64'(resp_valid_out), 64'd0);
    for (int k = 0; k < 3; k++) step(4'b0110, 1'b1, 1'b0, '0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
    check("t6_three_out", 64'(outstanding_out), 64'd3);
    do_reset();
    step(4'b1111, 1'b0, 1'b0, '0, 1'b0);
    check("t6_rst_count", 64'(outstanding_out), 64'd0);
    check("t6_rst_err", 64'(err_out), 64'd0);
    check("t6_rst_ptr", 64'(req_ready_out), 64'b0001);
    do_reset();
    step(4'b0000, 1'b0, 1'b1, 32'h7777, 1'b0);
    step(4'b0000, 1'b0, 1'b0, '0, 1'b0);
    check("t6_stale_resp_err", 64'(err_out), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) next_addr[i] = $urandom;
      rv_r = N'($urandom);
      if (inflight.size() > 0) rspv_r = ($urandom_range(99) < 40);
      else                     rspv_r = ($urandom_range(99) < 3);
      step(rv_r, $urandom_range(99) < 70, rspv_r, $urandom, $urandom_range(299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
